// File: rtl/calc_driver_if.sv
// calc_driver_if: request handshake, calculator tx bus, result and counters.
// Ports (members): req_valid/req_ready/req_a/req_op/req_b request side;
// tx_valid/tx_data/calc_out calculator side; res_valid/result/expected/
// mismatch/txn_count/err_count result side. slave = driver, master = host.
interface calc_driver_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [1:0]  req_op;
    logic [7:0]  req_b;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [7:0]  calc_out;
    logic        res_valid;
    logic [7:0]  result;
    logic [7:0]  expected;
    logic        mismatch;
    logic [15:0] txn_count;
    logic [15:0] err_count;

    modport slave (
        input  req_valid, req_a, req_op, req_b, calc_out,
        output req_ready, tx_valid, tx_data, res_valid,
        output result, expected, mismatch, txn_count, err_count
    );

    modport master (
        output req_valid, req_a, req_op, req_b, calc_out,
        input  req_ready, tx_valid, tx_data, res_valid,
        input  result, expected, mismatch, txn_count, err_count
    );
endinterface

// File: rtl/calc_driver.sv
// calc_driver: serialises one {a, op, b} request into three beats for the
// 8-bit calculator, captures its out, compares with a reference, counts.
// Ports: clk, rst (sync, active-high), bus (calc_driver_if.slave).
// Parameter GAP (0..15): idle cycles after beat A and after beat OP.
module calc_driver #(
    parameter int unsigned GAP = 0
) (
    input logic          clk,
    input logic          rst,
    calc_driver_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SEND_A, GAP_A, SEND_OP,
        GAP_OP, SEND_B, CAPTURE, DONE
    } state_t;

    localparam bit HAS_GAP = (GAP != 0);
    // Counter value loaded when a gap starts; the gap ends when it hits 0.
    localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [7:0]  a_q, b_q, exp_q;
    logic [1:0]  op_q;
    logic [3:0]  gap_q;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        res_valid_q, res_valid_d;
    logic [7:0]  result_q, expected_q;
    logic        mismatch_q;
    logic [15:0] txn_q, err_q;
    logic        accept;

    function automatic logic [7:0] ref_result(
        input logic [7:0] a,
        input logic [1:0] op,
        input logic [7:0] b
    );
        logic [7:0] r;
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a * b;
            default: r = a * a;
        endcase
        return r;
    endfunction

    assign accept = (state_q == IDLE) && bus.req_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = SEND_A;
            SEND_A:  state_d = HAS_GAP ? GAP_A : SEND_OP;
            GAP_A:   if (gap_q == 4'd0) state_d = SEND_OP;
            SEND_OP: state_d = HAS_GAP ? GAP_OP : SEND_B;
            GAP_OP:  if (gap_q == 4'd0) state_d = SEND_B;
            SEND_B:  state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
        endcase
    end

    // Output decode: values the registered outputs take next cycle.
    // SEND_A is only entered from IDLE, so req_a is still the live request.
    always_comb begin
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
        res_valid_d = 1'b0;
        case (state_d)
            SEND_A: begin
                tx_valid_d = 1'b1;
                tx_data_d  = bus.req_a;
            end
            SEND_OP: begin
                tx_valid_d = 1'b1;
                tx_data_d  = {6'b0, op_q};
            end
            SEND_B: begin
                tx_valid_d = 1'b1;
                tx_data_d  = b_q;
            end
            DONE:    res_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            exp_q       <= '0;
            gap_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            expected_q  <= '0;
            mismatch_q  <= 1'b0;
            txn_q       <= '0;
            err_q       <= '0;
        end else begin
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            res_valid_q <= res_valid_d;
            if (accept) begin
                a_q   <= bus.req_a;
                op_q  <= bus.req_op;
                b_q   <= bus.req_b;
                exp_q <= ref_result(bus.req_a, bus.req_op, bus.req_b);
            end
            if (state_q == SEND_A || state_q == SEND_OP) begin
                gap_q <= GAP_LAST;
            end else if (gap_q != 4'd0) begin
                gap_q <= gap_q - 4'd1;
            end
            if (state_q == CAPTURE) begin
                result_q   <= bus.calc_out;
                expected_q <= exp_q;
                mismatch_q <= (bus.calc_out != exp_q);
            end
            if (state_q == DONE) begin
                txn_q <= txn_q + 16'd1;
                if (mismatch_q && err_q != 16'hFFFF) begin
                    err_q <= err_q + 16'd1;
                end
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;
    assign bus.expected  = expected_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.txn_count = txn_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_calc_driver.sv
// tb_calc_driver: table-driven checks of calc_driver against a small
// calculator stand-in, with a result scoreboard and multi-cycle sequences.
module tb_calc_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;

    calc_driver_if b0();
    calc_driver_if b1();

    calc_driver #(.GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    calc_driver #(.GAP(2)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [1:0] op;
        logic [7:0] b;
        logic [7:0] res;
        bit         bad;
        bit         hold;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic [7:0] ex;
        logic       mm;
    } sb_t;

    sb_t   sbq[$];
    int    checks = 0;
    int    errors = 0;
    logic [15:0] txn_exp = '0;
    logic [15:0] err_exp = '0;
    bit    bad0 = 1'b0;

    // Calculator stand-in: three beats, out registered on the B beat.
    function automatic logic [7:0] calc_fn(
        input logic [7:0] a,
        input logic [1:0] op,
        input logic [7:0] b
    );
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return a * a;
        endcase
    endfunction

    logic [1:0] ph0, ph1;
    logic [7:0] ra0, ra1, co0, co1;
    logic [1:0] ro0, ro1;

    always @(posedge clk) begin
        if (rst) begin
            ph0 <= 2'd0; ra0 <= '0; ro0 <= '0; co0 <= '0;
            ph1 <= 2'd0; ra1 <= '0; ro1 <= '0; co1 <= '0;
        end else begin
            if (b0.tx_valid) begin
                case (ph0)
                    2'd0: begin ra0 <= b0.tx_data; ph0 <= 2'd1; end
                    2'd1: begin ro0 <= b0.tx_data[1:0]; ph0 <= 2'd2; end
                    default: begin
                        co0 <= calc_fn(ra0, ro0, b0.tx_data);
                        ph0 <= 2'd0;
                    end
                endcase
            end
            if (b1.tx_valid) begin
                case (ph1)
                    2'd0: begin ra1 <= b1.tx_data; ph1 <= 2'd1; end
                    2'd1: begin ro1 <= b1.tx_data[1:0]; ph1 <= 2'd2; end
                    default: begin
                        co1 <= calc_fn(ra1, ro1, b1.tx_data);
                        ph1 <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign b0.calc_out = bad0 ? 8'hAA : co0;
    assign b1.calc_out = co1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input vec_t v);
        logic [7:0] beats[$];
        sb_t s;
        int  k;
        bit  got;
        k = 0;
        while (!b0.req_ready && k < 20) begin
            tick();
            k++;
        end
        chk("ready_idle", 32'(b0.req_ready), 32'd1);
        bad0 = v.bad;
        b0.req_valid = 1'b1;
        b0.req_a = v.a;
        b0.req_op = v.op;
        b0.req_b = v.b;
        s.res = v.bad ? 8'hAA : v.res;
        s.ex = v.res;
        s.mm = v.bad;
        sbq.push_back(s);
        tick();
        if (v.hold) begin
            b0.req_a = 8'hEE;
            b0.req_op = 2'd2;
            b0.req_b = 8'h11;
        end else begin
            b0.req_valid = 1'b0;
        end
        got = 1'b0;
        for (k = 1; k <= 20; k++) begin
            if (b0.tx_valid) beats.push_back(b0.tx_data);
            if (v.hold && k <= 5)
                chk("busy_ready", 32'(b0.req_ready), 32'd0);
            if (b0.res_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        b0.req_valid = 1'b0;
        bad0 = 1'b0;
        chk("res_seen", 32'(got), 32'd1);
        if (got) begin
            chk("latency", 32'(k), 32'd5);
            s = sbq.pop_front();
            chk("result", 32'(b0.result), 32'(s.res));
            chk("expected", 32'(b0.expected), 32'(s.ex));
            chk("mismatch", 32'(b0.mismatch), 32'(s.mm));
        end
        chk("beat_cnt", 32'(beats.size()), 32'd3);
        if (beats.size() == 3) begin
            chk("beat_a", 32'(beats[0]), 32'(v.a));
            chk("beat_op", 32'(beats[1]), 32'(v.op));
            chk("beat_b", 32'(beats[2]), 32'(v.b));
        end
        txn_exp = txn_exp + 16'd1;
        if (v.bad && err_exp != 16'hFFFF) err_exp = err_exp + 16'd1;
        tick();
        chk("txn_count", 32'(b0.txn_count), 32'(txn_exp));
        chk("err_count", 32'(b0.err_count), 32'(err_exp));
        chk("ready_after", 32'(b0.req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        vec_t vr;
        logic [8:0] gexp[7];
        int  k;
        int  pulses;
        bit  got;

        tbl[0] = '{8'h05, 2'd0, 8'h03, 8'h08, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 2'd1, 8'h05, 8'hFE, 1'b0, 1'b1};
        tbl[2] = '{8'h14, 2'd2, 8'h0D, 8'h04, 1'b0, 1'b0};
        tbl[3] = '{8'h10, 2'd3, 8'h63, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'hFF, 2'd0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 2'd2, 8'hFF, 8'h01, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 2'd1, 8'h01, 8'hFF, 1'b0, 1'b0};
        tbl[7] = '{8'h01, 2'd0, 8'h01, 8'h02, 1'b1, 1'b0};
        vr     = '{8'h02, 2'd2, 8'h03, 8'h06, 1'b0, 1'b0};
        gexp = '{9'h101, 9'h001, 9'h001, 9'h100,
                 9'h000, 9'h000, 9'h101};

        b0.req_valid = 1'b0; b0.req_a = '0;
        b0.req_op = '0; b0.req_b = '0;
        b1.req_valid = 1'b0; b1.req_a = '0;
        b1.req_op = '0; b1.req_b = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(b0.req_ready), 32'd1);
        chk("rst_tx", 32'({b0.tx_valid, b0.tx_data}), 32'd0);
        chk("rst_res", 32'({b0.res_valid, b0.result,
                            b0.expected, b0.mismatch}), 32'd0);
        chk("rst_cnt", 32'({b0.txn_count, b0.err_count}), 32'd0);
        chk("rst_ready1", 32'(b1.req_ready), 32'd1);

        for (int i = 0; i < 8; i++) do_txn(tbl[i]);

        // Preload the error counter to its ceiling, then mismatch again.
        force dut0.err_q = 16'hFFFF;
        tick();
        release dut0.err_q;
        err_exp = 16'hFFFF;
        do_txn(tbl[7]);

        // GAP=2 instance: beat pattern with held data, then the result.
        b1.req_valid = 1'b1;
        b1.req_a = 8'h01;
        b1.req_op = 2'd0;
        b1.req_b = 8'h01;
        tick();
        b1.req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("gap_beat", 32'({b1.tx_valid, b1.tx_data}),
                32'(gexp[i]));
            tick();
        end
        got = 1'b0;
        for (k = 8; k <= 30; k++) begin
            if (b1.res_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("gap_seen", 32'(got), 32'd1);
        chk("gap_latency", 32'(k), 32'd9);
        chk("gap_result", 32'(b1.result), 32'h02);
        chk("gap_mismatch", 32'(b1.mismatch), 32'd0);
        tick();
        chk("gap_txn", 32'(b1.txn_count), 32'd1);

        // Reset during SEND_B aborts the request.
        b0.req_valid = 1'b1;
        b0.req_a = 8'h07;
        b0.req_op = 2'd0;
        b0.req_b = 8'h07;
        tick();
        b0.req_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_beat", 32'({b0.tx_valid, b0.tx_data}), 32'h107);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_tx", 32'(b0.tx_valid), 32'd0);
        chk("abort_ready", 32'(b0.req_ready), 32'd1);
        chk("abort_res", 32'(b0.res_valid), 32'd0);
        txn_exp = '0;
        err_exp = '0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b0.res_valid) pulses++;
        end
        chk("abort_nopulse", 32'(pulses), 32'd0);
        chk("abort_txn", 32'(b0.txn_count), 32'd0);
        do_txn(vr);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc_driver.md
# calc_driver

Transmit-side driver for the 8-bit serial calculator protocol. It accepts one parallel request (operand A, operator, operand B) through a ready/valid handshake and serialises it as three beats on the calculator's `valid`/`dataIn` bus. It then captures the calculator's registered `out`, checks it against an internally computed expected value, and keeps transaction and error counters. It sits between a test or host sequencer and the calculator, and shares `clk` and `rst` with it.

## Interface
Parameters:
- GAP, default 0: idle cycles inserted after beat A and after beat OP; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_a  in  8  operand A.
- req_op  in  2  operator: 0 add, 1 sub, 2 mul, 3 square A.
- req_b  in  8  operand B; still transmitted when op = 3.
- tx_valid  out  1  drives the calculator's `valid`.
- tx_data  out  8  drives the calculator's `dataIn`.
- calc_out  in  8  calculator's `out`.
- res_valid  out  1  one-cycle pulse: result, expected and mismatch are fresh.
- result  out  8  captured calc_out.
- expected  out  8  reference result, mod 256.
- mismatch  out  1  result != expected; qualified by res_valid.
- txn_count  out  16  completed transactions; wraps 0xFFFF to 0.
- err_count  out  16  mismatches; saturates at 0xFFFF.

## Operation
- States: IDLE, SEND_A, GAP_A, SEND_OP, GAP_OP, SEND_B, CAPTURE, DONE.
- IDLE, with req_valid=1:
  - latch a, op, b;
  - compute expected: a+b, a-b, a*b (low 8 bits), or a*a (low 8 bits); all arithmetic is unsigned mod 256;
  - go to SEND_A.
- SEND_A: tx_valid=1, tx_data=a.
  - GAP>0: next state GAP_A. GAP=0: next state SEND_OP.
- GAP_A: tx_valid=0, tx_data holds its previous value, for exactly GAP cycles (4-bit down-counter); then SEND_OP.
- SEND_OP: tx_valid=1, tx_data={6'b0, op}. Then GAP_OP (same gap rule as GAP_A), then SEND_B.
- SEND_B: tx_valid=1, tx_data=b. Next state CAPTURE.
- CAPTURE: tx_valid=0; register calc_out into result at the closing edge. Next state DONE.
- DONE:
  - res_valid=1;
  - txn_count increments;
  - err_count increments (saturating) if mismatch;
  - req_ready=0;
  - next state IDLE.
- Only one request is in flight at a time; there is no queueing. req_* are ignored outside IDLE.
- Reset values:
  - state IDLE;
  - req_ready 1 (combinational from IDLE after reset);
  - tx_valid 0, tx_data 0;
  - res_valid 0, result 0, expected 0, mismatch 0;
  - txn_count 0, err_count 0.
- Reset mid-sequence: abort immediately. The next cycle is IDLE with tx_valid=0, and no res_valid pulse is produced.
  - Because rst is shared, the calculator also returns to its first-operand state, so the protocol phase stays aligned.
- tx_valid is never asserted outside the SEND_* states. This prevents phase slip in the receiver.

## Timing
- All outputs are registered except req_ready, which is decoded from state.
- Accept edge E0 (req_valid & req_ready). With GAP=0:
  - cycle 1: beat A;
  - cycle 2: beat OP;
  - cycle 3: beat B;
  - cycle 4: CAPTURE. The calculator's out was updated at the end of cycle 3 and is stable here.
  - cycle 5: res_valid=1;
  - cycle 6: IDLE, req_ready=1, and the earliest next accept is at the end of cycle 6.
- Latency from accept to res_valid is 5 + 2*GAP cycles.
- Issue interval is 6 + 2*GAP cycles.
- result, expected and mismatch hold their values until the next DONE.
- Counters update at the edge that ends DONE, so they are visible the cycle after the res_valid pulse.

## Test plan
- Add, GAP=0, driving a real calculator instance: a=0x05, op=0, b=0x03.
  - Beats 05, 00, 03 on consecutive cycles.
  - res_valid 5 cycles after accept, result=0x08, mismatch=0, txn_count=1.
- Sub and mul wrap: a=0x03, op=1, b=0x05 gives result 0xFE. Then a=0x14, op=2, b=0x0D gives 0x04.
  - Both mismatch=0.
  - req_ready low for the whole sequence; a req_valid pulse held during busy is ignored.
- Square: a=0x10, op=3, b=0x63.
  - Beat B=0x63 is still sent.
  - result=0x00, expected=0x00.
- GAP=2: a=0x01, op=0, b=0x01.
  - Two tx_valid=0 cycles after beat A and after beat OP, with tx_data held.
  - res_valid 9 cycles after accept, result=0x02.
- Error path: force calc_out=0xAA during CAPTURE for a=0x01, op=0, b=0x01.
  - mismatch=1, err_count=1.
  - With err_count preloaded to 0xFFFF, another mismatch leaves it at 0xFFFF.
- Reset mid-sequence: assert rst during GAP_OP/SEND_B.
  - Next cycle: tx_valid=0, req_ready=1, no res_valid.
  - A subsequent a=0x02, op=2, b=0x03 returns 0x06 with mismatch=0.
